// File: rtl/window_pixel_feeder.sv
// Walks a WIN x WIN window over a stored frame in raster order and feeds each
// window row, binarised, into the classifier line buffer with a DONE handshake.
module window_pixel_feeder #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int WIN    = 20,
    parameter int STRIDE = 4,
    parameter int THRESH = 128,
    parameter int MEM_AW = 17
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FRAME_START,
    output logic              MEM_RD,
    output logic [MEM_AW-1:0] MEM_ADDR,
    input  logic [7:0]        MEM_DATA,
    output logic              START,
    output logic              PIX_VALID,
    output logic [8:0]        ADDR,
    output logic [31:0]       BW_out,
    input  logic              DONE,
    output logic [8:0]        WIN_X,
    output logic [8:0]        WIN_Y,
    output logic              BUSY,
    output logic              FRAME_DONE
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READ     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_ADVANCE  = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    localparam logic [8:0] WIN_L    = 9'(WIN);
    localparam logic [8:0] LAST_COL = 9'(WIN - 1);
    localparam logic [8:0] STRIDE_L = 9'(STRIDE);
    localparam logic [7:0] THRESH_L = 8'(THRESH);

    logic [2:0]        state_r, state_n;
    logic [8:0]        win_x_r, win_x_n;
    logic [8:0]        win_y_r, win_y_n;
    logic [8:0]        row_r, row_n;
    logic [8:0]        col_r, col_n;
    logic              busy_r, busy_n;
    logic              frame_done_r, frame_done_n;
    logic              issue_s;
    logic [8:0]        issue_col_s;
    logic              issue_first_s;
    logic [MEM_AW-1:0] issue_addr_s;
    logic              pix_bit_s;

    logic              mem_rd_r;
    logic [MEM_AW-1:0] mem_addr_r;
    logic [8:0]        rd_col_r;
    logic              rd_first_r;
    logic              pix_valid_r;
    logic [8:0]        addr_r;
    logic              start_r;
    logic              bw_hold_r;

    // Scan sequencer: next state, window origin, row/column counters, read issue.
    always_comb begin
        state_n      = state_r;
        win_x_n      = win_x_r;
        win_y_n      = win_y_r;
        row_n        = row_r;
        col_n        = col_r;
        busy_n       = busy_r;
        frame_done_n = 1'b0;
        issue_s      = 1'b0;
        issue_col_s  = 9'd0;
        case (state_r)
            ST_IDLE: begin
                if (FRAME_START) begin
                    win_x_n = 9'd0;
                    win_y_n = 9'd0;
                    row_n   = 9'd0;
                    col_n   = 9'd1;
                    busy_n  = 1'b1;
                    issue_s = 1'b1;
                    state_n = ST_READ;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_READ: begin
                if (col_r < WIN_L) begin
                    issue_s     = 1'b1;
                    issue_col_s = col_r;
                    col_n       = col_r + 9'd1;
                end else if (pix_valid_r && (addr_r == LAST_COL)) begin
                    state_n = ST_WAIT_ACK;
                end else begin
                    state_n = ST_READ;
                end
            end
            ST_WAIT_ACK: begin
                if (!DONE) begin
                    state_n = ST_WAIT_ACK;
                end else if ((row_r + 9'd1) < WIN_L) begin
                    row_n   = row_r + 9'd1;
                    col_n   = 9'd1;
                    issue_s = 1'b1;
                    state_n = ST_READ;
                end else begin
                    state_n = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                row_n = 9'd0;
                // The whole-window test is done before stepping so the last
                // origin stays visible on WIN_X/WIN_Y through FINISH.
                if ((int'(win_x_r) + STRIDE + WIN) <= IMG_W) begin
                    win_x_n = win_x_r + STRIDE_L;
                    col_n   = 9'd1;
                    issue_s = 1'b1;
                    state_n = ST_READ;
                end else if ((int'(win_y_r) + STRIDE + WIN) <= IMG_H) begin
                    win_x_n = 9'd0;
                    win_y_n = win_y_r + STRIDE_L;
                    col_n   = 9'd1;
                    issue_s = 1'b1;
                    state_n = ST_READ;
                end else begin
                    busy_n       = 1'b0;
                    frame_done_n = 1'b1;
                    state_n      = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // Row-major pixel address of the read being issued, from the next origin/row.
    always_comb begin
        issue_addr_s  = MEM_AW'((int'(win_y_n) + int'(row_n)) * IMG_W
                                + int'(win_x_n) + int'(issue_col_s));
        issue_first_s = issue_s && (issue_col_s == 9'd0) && (row_n == 9'd0);
        pix_bit_s     = (MEM_DATA >= THRESH_L);
    end

    // State, read-request and return-pipeline registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r      <= ST_IDLE;
            win_x_r      <= 9'd0;
            win_y_r      <= 9'd0;
            row_r        <= 9'd0;
            col_r        <= 9'd0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            mem_rd_r     <= 1'b0;
            mem_addr_r   <= '0;
            rd_col_r     <= 9'd0;
            rd_first_r   <= 1'b0;
            pix_valid_r  <= 1'b0;
            addr_r       <= 9'd0;
            start_r      <= 1'b0;
            bw_hold_r    <= 1'b0;
        end else begin
            state_r      <= state_n;
            win_x_r      <= win_x_n;
            win_y_r      <= win_y_n;
            row_r        <= row_n;
            col_r        <= col_n;
            busy_r       <= busy_n;
            frame_done_r <= frame_done_n;
            mem_rd_r     <= issue_s;
            rd_first_r   <= issue_first_s;
            if (issue_s) begin
                mem_addr_r <= issue_addr_s;
                rd_col_r   <= issue_col_s;
            end
            pix_valid_r <= mem_rd_r;
            start_r     <= mem_rd_r && rd_first_r;
            if (mem_rd_r) begin
                addr_r <= rd_col_r;
            end
            if (pix_valid_r) begin
                bw_hold_r <= pix_bit_s;
            end
        end
    end

    // Memory data arrives in the return cycle itself, so the pixel bit is
    // muxed straight through and only its held copy is registered.
    assign BW_out     = {31'd0, (pix_valid_r ? pix_bit_s : bw_hold_r)};
    assign MEM_RD     = mem_rd_r;
    assign MEM_ADDR   = mem_addr_r;
    assign START      = start_r;
    assign PIX_VALID  = pix_valid_r;
    assign ADDR       = addr_r;
    assign WIN_X      = win_x_r;
    assign WIN_Y      = win_y_r;
    assign BUSY       = busy_r;
    assign FRAME_DONE = frame_done_r;

endmodule

// File: doc/window_pixel_feeder.md
# window_pixel_feeder

Streams a stored grayscale frame into the window classifier, one 20-pixel window row at a time. It walks a WIN×WIN window across the image in raster order with a fixed stride. For each window row it reads pixels from frame memory, binarises them against a threshold, and drives the classifier's line-buffer write port (ADDR / BW). It then waits for the classifier's DONE before sending the next row. It sits between the frame store and the classifier, on the transmit side of the classifier's ADDR/BW_in/DONE interface.

## Interface
- IMG_W, 320: frame width in pixels.
- IMG_H, 240: frame height in pixels.
- WIN, 20: window edge in pixels; must match the classifier line-buffer depth.
- STRIDE, 4: window step in pixels, both axes.
- THRESH, 128: binarisation threshold; pixel ≥ THRESH → 1.
- MEM_AW, 17: frame-memory address width (≥ clog2(IMG_W*IMG_H)).
- CLK, in, 1: sole clock, rising edge.
- RESET, in, 1: synchronous, active-high reset.
- FRAME_START, in, 1: one-cycle request to scan the whole frame.
- MEM_RD, out, 1: frame-memory read strobe.
- MEM_ADDR, out, MEM_AW: pixel address, row-major (y*IMG_W + x).
- MEM_DATA, in, 8: read data, valid exactly 1 cycle after MEM_RD.
- START, out, 1: pulse marking the first pixel of a new window.
- PIX_VALID, out, 1: ADDR/BW_out carry a pixel this cycle.
- ADDR, out, 9: line-buffer index 0..WIN-1.
- BW_out, out, 32 (int): binarised pixel, 0 or 1.
- DONE, in, 1: classifier finished the current row.
- WIN_X, WIN_Y, out, 9 each: origin of the current window.
- BUSY, out, 1: scan in progress.
- FRAME_DONE, out, 1: one-cycle pulse after the last window completes.

## Operation
- States: IDLE, READ, WAIT_ACK, ADVANCE, FINISH.
- IDLE: outputs quiescent. FRAME_START → WIN_X=WIN_Y=0, row counter r=0, go to READ, BUSY=1.
- READ: 20 consecutive cycles with MEM_RD=1, MEM_ADDR=(WIN_Y+r)*IMG_W + WIN_X + c, for c=0..WIN-1.
  - Each return cycle drives PIX_VALID=1, ADDR=c, BW_out=(MEM_DATA≥THRESH).
  - After the return for c=WIN-1, go to WAIT_ACK.
- WAIT_ACK: hold PIX_VALID=0. On DONE=1: r++.
  - If r < WIN, go to READ.
  - Otherwise go to ADVANCE.
- ADVANCE (1 cycle): r=0 and WIN_X += STRIDE.
  - If WIN_X+STRIDE+WIN > IMG_W: WIN_X=0 and WIN_Y += STRIDE.
  - If the window also cannot move down (WIN_Y+STRIDE+WIN > IMG_H), go to FINISH instead of stepping.
  - Else go to READ.
- FINISH (1 cycle): FRAME_DONE=1, BUSY=0, go to IDLE.
- START=1 together with PIX_VALID on ADDR=0 of row r=0 of every window only.
- Address arithmetic is unsigned, computed at full MEM_AW width, with no wrap. The parameter set guarantees the maximum address is IMG_W*IMG_H-1.
- Default frame: 76 windows per row, 56 window rows, 4256 windows total. The last origin is (300, 220).

## Timing
- Reset values: MEM_RD=0, MEM_ADDR=0, START=0, PIX_VALID=0, ADDR=0, BW_out=0, WIN_X=0, WIN_Y=0, BUSY=0, FRAME_DONE=0. State is IDLE.
- ADDR and BW_out hold their last values when PIX_VALID=0; ADDR returns to 0 on reset only.
- Latency:
  - FRAME_START to first MEM_RD: 1 cycle.
  - MEM_RD to corresponding PIX_VALID: 1 cycle.
  - Row emission: 20 consecutive PIX_VALID cycles, the first one 1 cycle after the first MEM_RD.
  - DONE sampled in WAIT_ACK to next MEM_RD: 1 cycle.
- Boundary rules:
  - DONE outside WAIT_ACK is ignored.
  - DONE held high across rows counts once per WAIT_ACK entry, and only if it is high in a cycle while in WAIT_ACK.
  - No timeout in WAIT_ACK.
  - FRAME_START while BUSY=1 is ignored.
  - FRAME_START in the FINISH cycle is ignored; one in the following IDLE cycle is accepted.
  - RESET mid-scan: the next cycle is IDLE with all outputs at reset values. Any in-flight read return is discarded (PIX_VALID stays 0).
  - RESET has priority over FRAME_START and DONE.

## Test plan
- Reset and idle: RESET for 2 cycles, then idle for 10 cycles → all outputs 0, no MEM_RD.
- Single row: FRAME_START, with a memory model returning MEM_DATA=x (pixel x-coordinate)*7 mod 256.
  - Expect MEM_ADDR 0..19 on consecutive cycles.
  - Expect ADDR 0..19 with BW_out=1 exactly where data ≥ 128 (x ≥ 19).
  - Expect START only with ADDR=0; then PIX_VALID stays 0 until DONE.
- Handshake: delay DONE 50 cycles after row 0 → no MEM_RD during the wait. The next MEM_ADDR is 320 (row 1, x=0), 1 cycle after DONE.
- Window stepping: auto-DONE 3 cycles after each row.
  - Window 2 has origin (4,0) and first MEM_ADDR 4.
  - Window 77 has origin (0,4) and first MEM_ADDR 1280.
- Full frame: auto-DONE → exactly 4256 START pulses. The last window is at (300,220), the last MEM_ADDR is 76799, then one FRAME_DONE pulse, BUSY falls, and a second FRAME_START restarts at (0,0).
- Reset mid-window: RESET at row 5, column 10 of window 3 → all outputs 0 next cycle. A following FRAME_START restarts at origin (0,0), MEM_ADDR 0.
